// File: rtl/traffic_lamp_pkg.sv
// Shared types and constants for the traffic lamp monitor.
//   phase_e      : per-direction phase (UNK/RED/YEL/GRN)
//   ERR_*        : error codes reported on ERR_CODE
//   LAMP_*/FLD_* : bit positions of the six-lamp bus
//   decode_lamp  : 3-bit lamp field -> {ok, phase}
package traffic_lamp_pkg;

  typedef enum logic [1:0] {
    PH_UNK = 2'd0,
    PH_RED = 2'd1,
    PH_YEL = 2'd2,
    PH_GRN = 2'd3
  } phase_e;

  localparam logic [2:0] ERR_ENC       = 3'd1;
  localparam logic [2:0] ERR_CONFLICT  = 3'd2;
  localparam logic [2:0] ERR_SEQ       = 3'd3;
  localparam logic [2:0] ERR_YEL_SHORT = 3'd4;
  localparam logic [2:0] ERR_YEL_LONG  = 3'd5;
  localparam logic [2:0] ERR_GRN_SHORT = 3'd6;

  // Each direction occupies a 3-bit field: R, Y, G from LSB up.
  localparam int LAMP_FLD_W = 3;
  localparam int LAMP_A_LSB = 0;
  localparam int LAMP_B_LSB = 3;
  localparam int FLD_R      = 0;
  localparam int FLD_Y      = 1;
  localparam int FLD_G      = 2;

  typedef struct packed {
    logic   ok;
    phase_e ph;
  } lamp_dec_t;

  function automatic lamp_dec_t decode_lamp(input logic [LAMP_FLD_W-1:0] f);
    lamp_dec_t r;
    r.ok = $onehot(f);
    r.ph = PH_UNK;
    if (r.ok) begin
      if (f[FLD_G])      r.ph = PH_GRN;
      else if (f[FLD_Y]) r.ph = PH_YEL;
      else if (f[FLD_R]) r.ph = PH_RED;
    end
    return r;
  endfunction

endpackage

// File: rtl/traffic_lamp_monitor_if.sv
// Lamp bus between the traffic-light controller (master) and the monitor (slave).
//   LAMP     : [0]=A_R [1]=A_Y [2]=A_G [3]=B_R [4]=B_Y [5]=B_G
//   LAMP_VLD : sample qualifier
interface traffic_lamp_monitor_if;
  logic [5:0] LAMP;
  logic       LAMP_VLD;

  modport master (output LAMP, output LAMP_VLD);
  modport slave  (input  LAMP, input  LAMP_VLD);
endinterface

// File: rtl/traffic_lamp_monitor_lamp_dir_tracker.sv
// Per-direction phase tracker: FSM, dwell counter and the ENC/SEQ/timing checks.
//   clk, rstn : clock, synchronous active-low reset
//   vld       : sample qualifier; nothing advances when low
//   field     : this direction's 3-bit lamp field
//   state     : registered phase
//   nxt_state : phase this sample moves to (equals state when vld=0)
//   err       : violation flags indexed by error code (combinational, vld-gated)
module lamp_dir_tracker
  import traffic_lamp_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int YEL_MIN = 2,
  parameter int YEL_MAX = 8,
  parameter int GRN_MIN = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  vld,
  input  logic [LAMP_FLD_W-1:0] field,
  output logic [1:0]            state,
  output logic [1:0]            nxt_state,
  output logic [6:1]            err
);

  localparam logic [CNT_W-1:0] DW_MAX = '1;

  phase_e           state_q, state_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  lamp_dec_t        dec;
  logic             legal;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= PH_UNK;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    err     = '0;
    legal   = 1'b0;
    dec     = decode_lamp(field);
    if (vld) begin
      if (!dec.ok) begin
        err[ERR_ENC] = 1'b1;
        state_d      = PH_UNK;
        dwell_d      = '0;
      end else begin
        state_d = dec.ph;
        if (state_q == PH_UNK) begin
          // Resync: first clean value after UNK is trusted as-is.
          dwell_d = CNT_W'(1);
        end else if (dec.ph == state_q) begin
          dwell_d = (dwell_q == DW_MAX) ? dwell_q : dwell_q + CNT_W'(1);
          // Equality (not >=) so a long yellow is reported once per phase.
          if (state_q == PH_YEL && dwell_d == CNT_W'(YEL_MAX + 1))
            err[ERR_YEL_LONG] = 1'b1;
        end else begin
          dwell_d = CNT_W'(1);
          legal = (state_q == PH_GRN && dec.ph == PH_YEL) ||
                  (state_q == PH_YEL && dec.ph == PH_RED) ||
                  (state_q == PH_RED && dec.ph == PH_GRN);
          if (!legal) err[ERR_SEQ] = 1'b1;
          if (state_q == PH_YEL && dec.ph == PH_RED && dwell_q < CNT_W'(YEL_MIN))
            err[ERR_YEL_SHORT] = 1'b1;
          if (state_q == PH_GRN && dec.ph == PH_YEL && dwell_q < CNT_W'(GRN_MIN))
            err[ERR_GRN_SHORT] = 1'b1;
        end
      end
    end
  end

  assign state     = state_q;
  assign nxt_state = state_d;

endmodule

// File: rtl/traffic_lamp_monitor.sv
// Receive-side checker for the six-lamp traffic-light bus.
//   CK, RSTN   : clock, synchronous active-low reset
//   bus        : lamp bus (slave side): LAMP, LAMP_VLD
//   ERR_CLR    : clears the sticky error (a same-cycle violation still latches)
//   ERR        : sticky error flag, ERR_CODE / ERR_DIR hold the first violation
//   ERR_PULSE  : one cycle per sample with any violation
//   A_STATE/B_STATE : per-direction phase
//   CYCLES     : count of A RED->GRN moves, wrapping
module traffic_lamp_monitor
  import traffic_lamp_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int YEL_MIN = 2,
  parameter int YEL_MAX = 8,
  parameter int GRN_MIN = 4
) (
  input  logic                   CK,
  input  logic                   RSTN,
  traffic_lamp_monitor_if.slave  bus,
  input  logic                   ERR_CLR,
  output logic                   ERR,
  output logic [2:0]             ERR_CODE,
  output logic                   ERR_DIR,
  output logic                   ERR_PULSE,
  output logic [1:0]             A_STATE,
  output logic [1:0]             B_STATE,
  output logic [CNT_W-1:0]       CYCLES
);

  localparam int NUM_DIR = 2;

  logic [NUM_DIR-1:0][1:0] st, nxt;
  logic [NUM_DIR-1:0][6:1] derr;

  for (genvar d = 0; d < NUM_DIR; d++) begin : g_dir
    localparam int BASE = (d == 0) ? LAMP_A_LSB : LAMP_B_LSB;
    lamp_dir_tracker #(
      .CNT_W(CNT_W), .YEL_MIN(YEL_MIN), .YEL_MAX(YEL_MAX), .GRN_MIN(GRN_MIN)
    ) u_trk (
      .clk       (CK),
      .rstn      (RSTN),
      .vld       (bus.LAMP_VLD),
      .field     (bus.LAMP[BASE +: LAMP_FLD_W]),
      .state     (st[d]),
      .nxt_state (nxt[d]),
      .err       (derr[d])
    );
  end

  logic             err_q, err_d;
  logic [2:0]       code_q, code_d;
  logic             dir_q, dir_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic             conflict, any_err, a_r2g;
  logic [2:0]       sel_code;
  logic             sel_dir;

  always_comb begin
    conflict = bus.LAMP_VLD &&
               (nxt[0] == PH_YEL || nxt[0] == PH_GRN) &&
               (nxt[1] == PH_YEL || nxt[1] == PH_GRN);
    any_err  = (|derr[0]) || (|derr[1]) || conflict;

    // Walk codes high to low so the lowest code is written last; A after B
    // so A wins on a tie. CONFLICT is always attributed to A.
    sel_code = '0;
    sel_dir  = 1'b0;
    for (int c = 6; c >= 1; c--) begin
      if (derr[1][c]) begin sel_code = 3'(c); sel_dir = 1'b1; end
      if (derr[0][c]) begin sel_code = 3'(c); sel_dir = 1'b0; end
      if (c == int'(ERR_CONFLICT) && conflict) begin
        sel_code = ERR_CONFLICT;
        sel_dir  = 1'b0;
      end
    end

    err_d  = err_q;
    code_d = code_q;
    dir_d  = dir_q;
    if (any_err && (!err_q || ERR_CLR)) begin
      err_d  = 1'b1;
      code_d = sel_code;
      dir_d  = sel_dir;
    end else if (ERR_CLR) begin
      err_d  = 1'b0;
      code_d = '0;
      dir_d  = 1'b0;
    end
    pulse_d = any_err;

    // UNK->GRN is a resync, not a completed cycle.
    a_r2g    = bus.LAMP_VLD && st[0] == PH_RED && nxt[0] == PH_GRN;
    cycles_d = cycles_q + CNT_W'(a_r2g);
  end

  always_ff @(posedge CK) begin
    if (!RSTN) begin
      err_q    <= 1'b0;
      code_q   <= '0;
      dir_q    <= 1'b0;
      pulse_q  <= 1'b0;
      cycles_q <= '0;
    end else begin
      err_q    <= err_d;
      code_q   <= code_d;
      dir_q    <= dir_d;
      pulse_q  <= pulse_d;
      cycles_q <= cycles_d;
    end
  end

  assign ERR       = err_q;
  assign ERR_CODE  = code_q;
  assign ERR_DIR   = dir_q;
  assign ERR_PULSE = pulse_q;
  assign A_STATE   = st[0];
  assign B_STATE   = st[1];
  assign CYCLES    = cycles_q;

endmodule
